div_arbiter: RTL
================

// Module: div_arbiter
// PURPOSE
//  Round-robin scheduler that shares one fixed-point divider (start/A/B -> busy/valid/Q/ovf
//  handshake) between NUM_REQ requesters. It latches the granted requester's operands, pulses
//  the divider start, tracks busy/valid to completion and returns the quotient and overflow to
//  the owner, tagged by one-hot response. A watchdog converts a hung divider into an error response.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  WIDTH    10  operand/quotient width, matches divider A/B/Q
//  TIMEOUT  63  max cycles spent in WAIT_BUSY or in WAIT_DONE before error
// PORTS
//  clk         in   1              clock, all logic on rising edge
//  rst_n       in   1              synchronous reset, active low
//  req         in   NUM_REQ        request per requester, held high until its gnt
//  req_a       in   NUM_REQ*WIDTH  dividend per requester, slice i = [i*WIDTH +: WIDTH]
//  req_b       in   NUM_REQ*WIDTH  divisor per requester, same slicing
//  gnt         out  NUM_REQ        one-hot, 1-cycle pulse: operands of that requester taken
//  resp_valid  out  NUM_REQ        one-hot, 1-cycle pulse: result for that requester
//  resp_q      out  WIDTH          quotient, held from RESP until next RESP
//  resp_ovf    out  1              divider overflow flag, held like resp_q
//  resp_err    out  1              watchdog expired, held like resp_q
//  arb_busy    out  1              high in every state except IDLE
//  div_start   out  1              divider start, 1-cycle pulse
//  div_a       out  WIDTH          divider dividend, stable for whole transaction
//  div_b       out  WIDTH          divider divisor, stable for whole transaction
//  div_busy    in   1              divider busy
//  div_valid   in   1              divider result valid
//  div_q       in   WIDTH          divider quotient
//  div_ovf     in   1              divider overflow
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, rr pointer 0, all outputs 0. Reset mid-transaction
//   abandons it: no resp_valid issued for it; operands discarded.
//  FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
//  IDLE: arbitrate only if |req && !div_busy (a divider still busy from before reset blocks
//   issue). Winner = first req[i] at/after rr pointer, ascending, wrapping. At that edge:
//   latch div_a/div_b from winner slice, owner<=i, rr pointer<=(i+1)%NUM_REQ, go ISSUE.
//  ISSUE (1 cycle): gnt[owner]=1, div_start=1, timer cleared; next WAIT_BUSY.
//  WAIT_BUSY: div_valid=1 -> capture div_q/div_ovf, RESP (valid takes priority over busy);
//   else div_busy=1 -> WAIT_DONE, timer cleared; else timer++.
//  WAIT_DONE: div_valid=1 -> capture, RESP; else timer++.
//  Timeout: timer reaching TIMEOUT in WAIT_BUSY/WAIT_DONE -> resp_q=0, resp_ovf=0,
//   resp_err=1, RESP. Same-cycle div_valid beats timeout.
//  RESP (1 cycle): resp_valid[owner]=1; resp_q/resp_ovf/resp_err updated this cycle,
//   held until next RESP; next IDLE. Successful capture clears resp_err.
//  Latency: req sampled at edge T -> gnt/div_start in cycle T+1; resp_valid one cycle after
//   divider valid is seen. Minimum IDLE-to-IDLE = 4 cycles; IDLE dwell >= 1 cycle between jobs.
//  Fairness: with all req high, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more
//   than NUM_REQ-1 transactions. Requester dropping req before gnt is simply not served.
//  gnt and resp_valid are never both high; at most one bit of each set per cycle.
//  Divide-by-zero/overflow are the divider's concern: div_ovf is passed through unmodified.
// TESTING
//  1 Single req[2], A=10'h0C0 (3.0), B=10'h040 (1.0) -> gnt=4'b0100 1 cycle later, div_start
//    1 cycle, resp_valid=4'b0100 with resp_q=div_q, resp_ovf=0, resp_err=0.
//  2 req=4'b1111 held, 8 jobs -> gnt order 0,1,2,3,0,1,2,3; each resp_valid tagged to owner.
//  3 req[1], B=0 with divider raising ovf -> resp_valid[1]=1, resp_ovf=1, arbiter returns IDLE.
//  4 Divider model never asserts busy/valid -> after TIMEOUT(63) cycles resp_err=1, resp_q=0;
//    next request served normally and resp_err clears.
//  5 rst_n=0 in WAIT_DONE with div_busy=1 -> outputs 0, no resp_valid; new req not granted
//    until div_busy falls; rr pointer restarts at 0.
//  6 div_valid and timeout in same cycle -> normal capture, resp_err=0.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin front end that time-shares one fixed-point divider among NUM_REQ requesters.
// A watchdog turns a divider that never answers into an error response for the owner.
module div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 63
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           resp_q,
    output logic                       resp_ovf,
    output logic                       resp_err,
    output logic                       arb_busy,
    output logic                       div_start,
    output logic [WIDTH-1:0]           div_a,
    output logic [WIDTH-1:0]           div_b,
    input  logic                       div_busy,
    input  logic                       div_valid,
    input  logic [WIDTH-1:0]           div_q,
    input  logic                       div_ovf
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WBUSY = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             ovf;
        logic             err;
    } resp_t;

    logic [2:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [TW-1:0]    r_timer;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    resp_t            r_resp;

    logic [NUM_REQ-1:0][WIDTH-1:0] w_a_arr;
    logic [NUM_REQ-1:0][WIDTH-1:0] w_b_arr;
    logic                          w_found;
    logic [IW-1:0]                 w_win;
    logic                          w_tmo;
    resp_t                         w_cap;
    resp_t                         w_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First active request at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_tmo = (r_timer == TW'(TIMEOUT - 1));
    assign w_cap = {div_q, div_ovf, 1'b0};
    assign w_err = {{WIDTH{1'b0}}, 1'b0, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_timer <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A divider still busy from before a reset must drain first.
                    if (w_found && !div_busy) begin
                        r_div_a <= w_a_arr[w_win];
                        r_div_b <= w_b_arr[w_win];
                        r_owner <= w_win;
                        r_ptr   <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + IW'(1);
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WBUSY;
                end
                S_WBUSY, S_WDONE: begin
                    // Result beats watchdog; watchdog beats the busy hand-off.
                    if (div_valid) begin
                        r_resp  <= w_cap;
                        r_state <= S_RESP;
                    end else if (w_tmo) begin
                        r_resp  <= w_err;
                        r_state <= S_RESP;
                    end else if (r_state == S_WBUSY && div_busy) begin
                        r_timer <= '0;
                        r_state <= S_WDONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt        = (r_state == S_ISSUE) ? (NUM_REQ'(1) << r_owner) : '0;
    assign resp_valid = (r_state == S_RESP)  ? (NUM_REQ'(1) << r_owner) : '0;
    assign div_start  = (r_state == S_ISSUE);
    assign arb_busy   = (r_state != S_IDLE);
    assign div_a      = r_div_a;
    assign div_b      = r_div_b;
    assign resp_q     = r_resp.q;
    assign resp_ovf   = r_resp.ovf;
    assign resp_err   = r_resp.err;

endmodule
